// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Port 0 is the pipeline EX stage and port 1 is the auxiliary requester.
// The winning request is registered into an issue stage. That stage drives
// the shared ALU. The result is registered and returned to the owning port
// two cycles after acceptance.
// Optional feature: define ALU_ARB_RR_EN for round-robin tie breaking.
// Without it, port 0 always wins ties.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FUNW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_A0,
    input  logic [WIDTH-1:0] req_B0,
    input  logic [WIDTH-1:0] req_A1,
    input  logic [WIDTH-1:0] req_B1,
    input  logic [FUNW-1:0]  req_ALUFun0,
    input  logic [FUNW-1:0]  req_ALUFun1,
    input  logic             req_Sign0,
    input  logic             req_Sign1,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [FUNW-1:0]  alu_ALUFun,
    output logic             alu_Sign,
    input  logic [WIDTH-1:0] alu_Z,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_Z,
    output logic             busy
);

    logic [1:0]       grant;
    logic [1:0]       acc;

    logic             iss_v;
    logic             iss_id;
    logic [WIDTH-1:0] iss_a;
    logic [WIDTH-1:0] iss_b;
    logic [FUNW-1:0]  iss_fun;
    logic             iss_sign;

    logic             res_v;
    logic             res_id;

`ifdef ALU_ARB_RR_EN
    // Preferred port for the next tie; 0 after reset.
    logic rr_ptr;

    // Tie goes to the preferred port; a lone request always wins.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11)
            grant = rr_ptr ? 2'b10 : 2'b01;
    end

    // After an accept from port k, prefer the other port. Flush leaves the pointer alone.
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (|acc)
            rr_ptr <= acc[0];
    end
`else
    // Fixed priority: port 0 always wins.
    always_comb begin
        grant = {req_valid[1] & ~req_valid[0], req_valid[0]};
    end
`endif

    // No grants while the pipeline is being killed.
    always_comb begin
        req_ready = (reset | flush) ? 2'b00 : grant;
        acc       = req_valid & req_ready;
    end

    // Issue stage: capture the accepted op. It is empty whenever nothing was accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_v    <= 1'b0;
            iss_id   <= 1'b0;
            iss_a    <= '0;
            iss_b    <= '0;
            iss_fun  <= '0;
            iss_sign <= 1'b0;
        end else begin
            iss_v <= |acc;
            if (|acc) begin
                iss_id   <= acc[1];
                iss_a    <= acc[1] ? req_A1      : req_A0;
                iss_b    <= acc[1] ? req_B1      : req_B0;
                iss_fun  <= acc[1] ? req_ALUFun1 : req_ALUFun0;
                iss_sign <= acc[1] ? req_Sign1   : req_Sign0;
            end
        end
    end

    // Drive the shared ALU from the issue stage. Drive zeros when it is empty.
    always_comb begin
        alu_A      = iss_v ? iss_a    : '0;
        alu_B      = iss_v ? iss_b    : '0;
        alu_ALUFun = iss_v ? iss_fun  : '0;
        alu_Sign   = iss_v ? iss_sign : 1'b0;
    end

    // Result stage. A flushed op never reaches it, and rsp_Z keeps the last real result.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_v  <= 1'b0;
            res_id <= 1'b0;
            rsp_Z  <= '0;
        end else begin
            res_v  <= iss_v & ~flush;
            res_id <= iss_id;
            if (iss_v & ~flush)
                rsp_Z <= alu_Z;
        end
    end

    // Steer the response pulse to the owning port.
    always_comb begin
        rsp_valid = 2'b00;
        if (res_v)
            rsp_valid = res_id ? 2'b10 : 2'b01;
        busy = iss_v | res_v;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. A small behavioural ALU closes the loop on
// alu_*/alu_Z. Expected values are hand-computed constants.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [1:0]  req_valid, req_ready, rsp_valid;
    logic [31:0] req_A0, req_B0, req_A1, req_B1;
    logic [5:0]  req_ALUFun0, req_ALUFun1;
    logic        req_Sign0, req_Sign1;
    logic [31:0] alu_A, alu_B, alu_Z, rsp_Z;
    logic [5:0]  alu_ALUFun;
    logic        alu_Sign, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .FUNW(6)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A0(req_A0), .req_B0(req_B0), .req_A1(req_A1), .req_B1(req_B1),
        .req_ALUFun0(req_ALUFun0), .req_ALUFun1(req_ALUFun1),
        .req_Sign0(req_Sign0), .req_Sign1(req_Sign1),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUFun(alu_ALUFun), .alu_Sign(alu_Sign),
        .alu_Z(alu_Z), .rsp_valid(rsp_valid), .rsp_Z(rsp_Z), .busy(busy)
    );

    // Shared ALU model: add, sub, xor, less-than.
    always_comb begin
        alu_Z = 32'h0;
        case (alu_ALUFun)
            6'b000000: alu_Z = alu_A + alu_B;
            6'b000001: alu_Z = alu_A - alu_B;
            6'b010110: alu_Z = alu_A ^ alu_B;
            6'b110101: alu_Z = {31'b0, alu_Sign ? ($signed(alu_A) < $signed(alu_B)) : (alu_A < alu_B)};
            default:   alu_Z = 32'h0;
        endcase
    end

    // Bound the run in case something stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, summary not printed");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; req_valid = 2'b00;
        req_A0 = '0; req_B0 = '0; req_A1 = '0; req_B1 = '0;
        req_ALUFun0 = '0; req_ALUFun1 = '0; req_Sign0 = 1'b0; req_Sign1 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({alu_A, alu_B, alu_ALUFun, alu_Sign} !== '0) begin failures++; $display("FAIL reset_alu got A=%h B=%h F=%b S=%b exp 0", alu_A, alu_B, alu_ALUFun, alu_Sign); end
        checks++; if (rsp_Z !== 32'h0) begin failures++; $display("FAIL reset_rsp_Z got=%h exp=0", rsp_Z); end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        tick();                                       // cycle 1
        req_valid = 2'b01; req_A0 = 32'd5; req_B0 = 32'd7; req_ALUFun0 = 6'b000000;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_c1 got=%b exp=0", busy); end
        tick();                                       // cycle 2
        idle_inputs();
        checks++; if (alu_A !== 32'd5 || alu_B !== 32'd7) begin failures++; $display("FAIL single_alu got A=%h B=%h exp 5 7", alu_A, alu_B); end
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin failures++; $display("FAIL single_c2 got rv=%b busy=%b exp 00 1", rsp_valid, busy); end
        tick();                                       // cycle 3
        checks++; if (rsp_valid !== 2'b01 || rsp_Z !== 32'd12) begin failures++; $display("FAIL single_rsp got rv=%b Z=%h exp 01 c", rsp_valid, rsp_Z); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_c3 got=%b exp=1", busy); end
        tick();                                       // cycle 4
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL single_c4 got rv=%b busy=%b exp 00 0", rsp_valid, busy); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g [4];
        logic [31:0] exp_z [4];
`ifdef ALU_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_z = '{32'd7, 32'hFF, 32'd7, 32'hFF};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_z = '{32'd7, 32'd7, 32'd7, 32'd7};
`endif
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) begin
                req_valid = 2'b11;
                req_A0 = 32'd10;   req_B0 = 32'd3;   req_ALUFun0 = 6'b000001;
                req_A1 = 32'hF0;   req_B1 = 32'h0F;  req_ALUFun1 = 6'b010110;
            end else begin
                idle_inputs();
            end
            #1;
            if (i < 4) begin
                checks++; if (req_ready !== exp_g[i]) begin failures++; $display("FAIL contend_grant%0d got=%b exp=%b", i, req_ready, exp_g[i]); end
            end
            if (i >= 2) begin
                checks++;
                if (rsp_valid !== exp_g[i-2] || rsp_Z !== exp_z[i-2]) begin
                    failures++; $display("FAIL contend_rsp%0d got rv=%b Z=%h exp %b %h", i-2, rsp_valid, rsp_Z, exp_g[i-2], exp_z[i-2]);
                end
            end
        end
    endtask

    task automatic test_signed();
        do_reset();
        tick();                                       // cycle 1
        req_valid = 2'b10; req_A1 = 32'hFFFFFFFF; req_B1 = 32'd1; req_ALUFun1 = 6'b110101; req_Sign1 = 1'b1;
        tick();                                       // cycle 2
        req_Sign1 = 1'b0;
        #1;
        checks++; if (alu_Sign !== 1'b1 || alu_ALUFun !== 6'b110101) begin failures++; $display("FAIL signed_alu got S=%b F=%b exp 1 110101", alu_Sign, alu_ALUFun); end
        tick();                                       // cycle 3
        idle_inputs();
        checks++; if (rsp_valid !== 2'b10 || rsp_Z !== 32'd1) begin failures++; $display("FAIL signed_lt got rv=%b Z=%h exp 10 1", rsp_valid, rsp_Z); end
        tick();                                       // cycle 4
        checks++; if (rsp_valid !== 2'b10 || rsp_Z !== 32'd0) begin failures++; $display("FAIL unsigned_lt got rv=%b Z=%h exp 10 0", rsp_valid, rsp_Z); end
    endtask

    task automatic test_flush();
        do_reset();
        tick();                                       // cycle 1
        req_valid = 2'b01; req_A0 = 32'd1; req_B0 = 32'd1;
        tick();                                       // cycle 2
        req_A0 = 32'd2; req_B0 = 32'd2; flush = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL flush_ready got=%b exp=00", req_ready); end
        tick();                                       // cycle 3
        flush = 1'b0; req_A0 = 32'd3; req_B0 = 32'd4;
        #1;
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL flush_c3 got rv=%b busy=%b exp 00 0", rsp_valid, busy); end
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL flush_reaccept got=%b exp=01", req_ready); end
        tick();                                       // cycle 4
        idle_inputs();
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL flush_c4 got rv=%b exp 00", rsp_valid); end
        tick();                                       // cycle 5
        checks++; if (rsp_valid !== 2'b01 || rsp_Z !== 32'd7) begin failures++; $display("FAIL flush_new got rv=%b Z=%h exp 01 7", rsp_valid, rsp_Z); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            req_valid = 2'b01; req_A0 = i; req_B0 = 32'd10;
        end
        tick();                                       // cycle 4
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rstmid_ready got=%b exp=00", req_ready); end
        tick();                                       // cycle 5
        reset = 1'b0; idle_inputs();
        #1;
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL rstmid_c5 got rv=%b busy=%b rdy=%b exp 00 0 00", rsp_valid, busy, req_ready); end
        checks++; if ({alu_A, alu_B, alu_ALUFun, alu_Sign} !== '0 || rsp_Z !== 32'h0) begin failures++; $display("FAIL rstmid_data got A=%h Z=%h exp 0 0", alu_A, rsp_Z); end
        tick();                                       // cycle 6: first tie after reset
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rstmid_tie got=%b exp=01", req_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rstmid_stale got rv=%b exp 00", rsp_valid); end
    endtask

    task automatic test_idle();
        do_reset();
        tick();                                       // cycle 1
        req_valid = 2'b01; req_A0 = 32'd20; req_B0 = 32'd22;
        tick();
        idle_inputs();
        tick();                                       // cycle 3: result 42
        checks++; if (rsp_valid !== 2'b01 || rsp_Z !== 32'd42) begin failures++; $display("FAIL idle_pre got rv=%b Z=%h exp 01 2a", rsp_valid, rsp_Z); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({alu_A, alu_B, alu_ALUFun, alu_Sign} !== '0 || rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_Z !== 32'd42) begin
                failures++; $display("FAIL idle%0d got A=%h rv=%b busy=%b Z=%h exp 0 00 0 2a", i, alu_A, rsp_valid, busy, rsp_Z);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_signed();
        test_flush();
        test_reset_midstream();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
